// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, FSM state type and 28-bit half rotations.
// Table entries use 1-based DES bit numbers; vector index = DES bit - 1.
package des_pkg;

    typedef enum logic {IDLE, RUN} state_e;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // DES "left" moves DES bit 2 into bit 1, i.e. toward index 0.
    function automatic logic [27:0] rot_left(input logic [27:0] h, input int n);
        logic [27:0] r;
        r = h;
        for (int k = 0; k < 2; k++) begin
            if (k < n) r = {r[0], r[27:1]};
        end
        return r;
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] h, input int n);
        logic [27:0] r;
        r = h;
        for (int k = 0; k < 2; k++) begin
            if (k < n) r = {r[26:0], r[27]};
        end
        return r;
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic right, input int n);
        if (right) return {rot_right(cd[55:28], n), rot_right(cd[27:0], n)};
        return {rot_left(cd[55:28], n), rot_left(cd[27:0], n)};
    endfunction

endpackage

// File: rtl/des_pc1.sv
// Permuted Choice 1: drops the eight parity bits and reorders the key into C/D.
module des_pc1
    import des_pkg::*;
(
    input  logic [63:0] key_i,
    output logic [55:0] cd_o
);

    for (genvar j = 0; j < 56; j++) begin : g_pc1
        assign cd_o[j] = key_i[PC1_TBL[j] - 1];
    end

    // DES bits 8,16,..,64 carry parity only and never reach C/D.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key_i[63], key_i[55], key_i[47], key_i[39],
                                  key_i[31], key_i[23], key_i[15], key_i[7]};

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES round-key generator: PC-1 at key accept, C/D rotate register,
// PC-2 on the register output, one round key per output handshake.
module des_key_sched
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS   = 16,
    parameter int PARITY_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    output logic        rk_valid_o,
    input  logic        rk_ready_i,
    output logic [47:0] rk_o,
    output logic [3:0]  round_o,
    output logic        last_o,
    output logic        parity_err_o
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    state_e      state_q;
    logic [55:0] cd_q;
    logic [55:0] cd_pc1;
    logic [55:0] cd_load_d;
    logic [55:0] cd_rot_d;
    logic        dec_q;
    logic [3:0]  round_q;
    logic [3:0]  sh_idx;
    logic        perr_q;
    logic        key_even;

    des_pc1 u_pc1 (
        .key_i (key_i),
        .cd_o  (cd_pc1)
    );

    always_comb begin
        key_even = 1'b0;
        for (int j = 0; j < 8; j++) begin
            key_even = key_even | ~^key_i[8*j +: 8];
        end
    end

    // Decrypt starts at C16D16, which equals C0D0, so it loads unrotated.
    assign sh_idx    = dec_q ? (4'd15 - round_q) : (round_q + 4'd1);
    assign cd_load_d = decrypt_i ? cd_pc1 : rot_cd(cd_pc1, 1'b0, SHIFT[0]);
    assign cd_rot_d  = rot_cd(cd_q, dec_q, SHIFT[sh_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cd_q    <= '0;
            dec_q   <= 1'b0;
            round_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid_i) begin
                        cd_q    <= cd_load_d;
                        dec_q   <= decrypt_i;
                        round_q <= '0;
                        perr_q  <= (PARITY_CHECK != 0) && key_even;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (rk_ready_i) begin
                        if (round_q == LAST_RND) begin
                            round_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            cd_q    <= cd_rot_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        assign rk_o[j] = cd_q[PC2_TBL[j] - 1];
    end

    assign key_ready_o  = (state_q == IDLE);
    assign rk_valid_o   = (state_q == RUN);
    assign round_o      = round_q;
    assign last_o       = (state_q == RUN) && (round_q == LAST_RND);
    assign parity_err_o = perr_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched using the classic 0x133457799BBCDFF1 key schedule.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid_i = 1'b0;
    logic        key_ready_o;
    logic [63:0] key_i = '0;
    logic        decrypt_i = 1'b0;
    logic        rk_valid_o;
    logic        rk_ready_i = 1'b1;
    logic [47:0] rk_o;
    logic [3:0]  round_o;
    logic        last_o;
    logic        parity_err_o;

    int ncmp  = 0;
    int nfail = 0;

    des_key_sched dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid_i  (key_valid_i),
        .key_ready_o  (key_ready_o),
        .key_i        (key_i),
        .decrypt_i    (decrypt_i),
        .rk_valid_o   (rk_valid_o),
        .rk_ready_i   (rk_ready_i),
        .rk_o         (rk_o),
        .round_o      (round_o),
        .last_o       (last_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    // Standard K1..K16 written MSB = DES bit 1.
    logic [47:0] kexp [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47-i];
        return r;
    endfunction

    function automatic logic [27:0] rev28(input logic [27:0] v);
        logic [27:0] r;
        for (int i = 0; i < 28; i++) r[i] = v[27-i];
        return r;
    endfunction

    logic [63:0] key_good;
    logic [63:0] key_other;
    logic [55:0] cd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [63:0] k, input logic dec);
        key_i       = k;
        decrypt_i   = dec;
        key_valid_i = 1'b1;
        chk("accept_ready", 64'(key_ready_o), 64'd1);
        @(posedge clk); #1;
        key_valid_i = 1'b0;
        key_i       = ~k;
        decrypt_i   = ~dec;
    endtask

    // Walks one key sequence; optional stall, mid-run reset and busy poke.
    task automatic run_seq(input logic dec, input logic chk_keys, input int stall_at,
                           input int abort_at, input logic poke);
        logic [47:0] exp;
        for (int r = 0; r < 16; r++) begin
            exp = dec ? kexp[15-r] : kexp[r];
            chk($sformatf("valid_r%0d", r), 64'(rk_valid_o), 64'd1);
            chk($sformatf("round_r%0d", r), 64'(round_o), 64'(r));
            chk($sformatf("last_r%0d", r), 64'(last_o), 64'(r == 15));
            if (chk_keys) begin
                chk($sformatf("%s_key_r%0d", dec ? "dec" : "enc", r), 64'(rev48(rk_o)), 64'(exp));
                if ((!dec && r == 15) || (dec && r == 0))
                    chk("cd_wrap", 64'(dut.cd_q), 64'(cd0));
            end
            if (r == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk("abort_valid", 64'(rk_valid_o), 64'd0);
                chk("abort_ready", 64'(key_ready_o), 64'd1);
                chk("abort_round", 64'(round_o), 64'd0);
                chk("abort_rk", 64'(rk_o), 64'd0);
                #2 rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (r == stall_at) begin
                rk_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    chk($sformatf("stall_round_s%0d", s), 64'(round_o), 64'(r));
                    chk($sformatf("stall_key_s%0d", s), 64'(rev48(rk_o)), 64'(exp));
                end
                rk_ready_i = 1'b1;
            end
            if (poke && r == 2) begin
                key_i       = key_other;
                decrypt_i   = 1'b1;
                key_valid_i = 1'b1;
                chk("busy_ready", 64'(key_ready_o), 64'd0);
            end
            @(posedge clk); #1;
            key_valid_i = 1'b0;
        end
        chk("end_valid", 64'(rk_valid_o), 64'd0);
        chk("end_ready", 64'(key_ready_o), 64'd1);
        chk("end_round", 64'(round_o), 64'd0);
    endtask

    initial begin
        key_good  = rev64(64'h133457799BBCDFF1);
        key_other = rev64(64'h0E329232EA6D0D73);
        cd0       = {rev28(28'b0101010101100110011110001111),
                     rev28(28'b1111000011001100101010101111)};

        #2;
        chk("rst_valid", 64'(rk_valid_o), 64'd0);
        chk("rst_ready", 64'(key_ready_o), 64'd1);
        chk("rst_round", 64'(round_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_perr", 64'(parity_err_o), 64'd0);
        chk("rst_rk", 64'(rk_o), 64'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        accept(key_good, 1'b0);
        chk("enc_perr", 64'(parity_err_o), 64'd0);
        run_seq(1'b0, 1'b1, -1, -1, 1'b0);

        accept(key_good, 1'b1);
        run_seq(1'b1, 1'b1, -1, -1, 1'b0);

        accept(key_good, 1'b0);
        run_seq(1'b0, 1'b1, 3, -1, 1'b0);

        accept(key_good ^ 64'd1, 1'b0);
        chk("bad_perr", 64'(parity_err_o), 64'd1);
        run_seq(1'b0, 1'b0, -1, -1, 1'b0);
        chk("bad_perr_held", 64'(parity_err_o), 64'd1);

        accept(key_good, 1'b0);
        chk("good_perr", 64'(parity_err_o), 64'd0);
        run_seq(1'b0, 1'b1, -1, 7, 1'b0);

        accept(key_good, 1'b0);
        run_seq(1'b0, 1'b1, -1, -1, 1'b0);

        accept(key_good, 1'b0);
        run_seq(1'b0, 1'b1, -1, -1, 1'b1);
        accept(key_good, 1'b0);
        run_seq(1'b0, 1'b1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
